// File: rtl/programmable_line_buffer.sv
// Programmable line buffer: a cascade of pNoTaps delay taps. Each tap delays
// its input by D enabled shifts, where D is latched (and clamped) only at
// reset or clear. Each tap stage is a circular buffer with a shared pointer.
//
// Handshake: there is no backpressure. Every cycle with enable=1 (and no
// reset/clear) accepts exactly one sample from shift_in; all outputs are
// updated on that edge and held on every other cycle.
module programmable_line_buffer #(
  parameter int pNoTaps      = 3,
  parameter int pMaxDelay    = 16,
  parameter int pPtrLength   = 5,
  parameter int pDataLength  = 16,
  parameter int pCountLength = 6
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             enable,
  input  logic [pPtrLength-1:0]            delay_len,
  input  logic [pDataLength-1:0]           shift_in,
  output logic [pDataLength*pNoTaps-1:0]   taps,
  output logic [pNoTaps-1:0]               tap_valid,
  output logic                             full,
  output logic [pCountLength-1:0]          fill_count
);

  localparam int AW = (pMaxDelay > 1) ? $clog2(pMaxDelay) : 1;
  localparam int CW1 = pCountLength + 1;
  localparam logic [pPtrLength-1:0]   PTR_MAX = pPtrLength'(pMaxDelay);
  localparam logic [pCountLength-1:0] CNT_MAX = pCountLength'(pNoTaps * pMaxDelay);

  logic [pPtrLength-1:0]   r_delay;
  logic [pPtrLength-1:0]   r_ptr;
  logic [pCountLength-1:0] r_count;
  logic [pNoTaps-1:0]      r_valid;
  logic [pDataLength-1:0]  r_raw [pNoTaps];
  logic [pDataLength-1:0]  r_mem [pNoTaps][pMaxDelay];

  logic [pPtrLength-1:0]   w_delay_clamped;
  logic [pPtrLength-1:0]   w_rd_ptr;
  logic [AW-1:0]           w_wr_idx;
  logic [AW-1:0]           w_rd_idx;
  logic [pCountLength-1:0] w_count_next;
  logic [pNoTaps-1:0]      w_valid_next;
  logic [pDataLength-1:0]  w_stage_in  [pNoTaps];
  logic [pDataLength-1:0]  w_stage_out [pNoTaps];
  logic                    w_flush;
  logic                    w_shift;

  assign w_flush = !reset_n || clear;
  assign w_shift = !w_flush && enable;

  // Clamp the requested delay into 1..pMaxDelay before it is latched.
  always_comb begin
    w_delay_clamped = delay_len;
    if (delay_len == '0) begin
      w_delay_clamped = pPtrLength'(1);
    end else if (delay_len > PTR_MAX) begin
      w_delay_clamped = PTR_MAX;
    end
  end

  // The read slot is the one after the write slot: it holds the sample
  // written D-1 shifts ago, which together with the output register gives
  // a total delay of D-1 relative to the accepting edge (tap0 = x(n+1-D)).
  always_comb begin
    w_rd_ptr = (r_ptr == r_delay - pPtrLength'(1)) ? '0 : r_ptr + pPtrLength'(1);
    w_wr_idx = r_ptr[AW-1:0];
    w_rd_idx = w_rd_ptr[AW-1:0];
  end

  // Next fill count saturates; tap i becomes valid once n >= (i+1)*D.
  always_comb begin
    w_count_next = (r_count == CNT_MAX) ? r_count : r_count + pCountLength'(1);
    w_valid_next = '0;
    for (int i = 0; i < pNoTaps; i++) begin
      w_valid_next[i] = ({1'b0, w_count_next} >= (CW1'(i + 1) * CW1'(r_delay)));
    end
  end

  // Stage inputs chain tap to tap; D=1 bypasses storage since read==write slot.
  always_comb begin
    for (int i = 0; i < pNoTaps; i++) begin
      w_stage_in[i]  = '0;
      w_stage_out[i] = '0;
    end
    for (int i = 0; i < pNoTaps; i++) begin
      w_stage_in[i]  = (i == 0) ? shift_in : r_raw[(i == 0) ? 0 : i - 1];
      w_stage_out[i] = (r_delay == pPtrLength'(1)) ? w_stage_in[i] : r_mem[i][w_rd_idx];
    end
  end

  // Control and tap registers: flush latches D and zeroes state; shift advances.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_delay <= w_delay_clamped;
      r_ptr   <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < pNoTaps; i++) begin
        r_raw[i] <= '0;
      end
    end else if (enable) begin
      r_ptr   <= w_rd_ptr;
      r_count <= w_count_next;
      r_valid <= w_valid_next;
      for (int i = 0; i < pNoTaps; i++) begin
        r_raw[i] <= w_stage_out[i];
      end
    end
  end

  // Storage is never erased; stale contents are masked by the valid flags.
  always_ff @(posedge clk) begin
    if (w_shift) begin
      for (int i = 0; i < pNoTaps; i++) begin
        r_mem[i][w_wr_idx] <= w_stage_in[i];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < pNoTaps; g++) begin : g_taps
      assign taps[pDataLength*g +: pDataLength] = r_valid[g] ? r_raw[g] : '0;
    end
  endgenerate

  assign tap_valid  = r_valid;
  assign full       = &r_valid;
  assign fill_count = r_count;

endmodule

// File: tb/tb_programmable_line_buffer.sv
// Directed bench for programmable_line_buffer with default parameters.
module tb_programmable_line_buffer;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        enable;
  logic [4:0]  delay_len;
  logic [15:0] shift_in;
  logic [47:0] taps;
  logic [2:0]  tap_valid;
  logic        full;
  logic [5:0]  fill_count;

  int checks = 0;
  int errors = 0;

  programmable_line_buffer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .enable     (enable),
    .delay_len  (delay_len),
    .shift_in   (shift_in),
    .taps       (taps),
    .tap_valid  (tap_valid),
    .full       (full),
    .fill_count (fill_count)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic rst_n, input logic clr, input logic en,
                       input logic [15:0] din, input logic [4:0] dl);
    reset_n   = rst_n;
    clear     = clr;
    enable    = en;
    shift_in  = din;
    delay_len = dl;
    @(posedge clk);
    #1;
  endtask

  // Reference: after n accepted samples x_k = base+k-1, tap i = x(n+1-(i+1)*d).
  function automatic logic [15:0] f_tap(int n, int d, int i, int base);
    int idx;
    idx = n + 1 - (i + 1) * d;
    return (idx >= 1) ? 16'(base + idx - 1) : 16'd0;
  endfunction

  function automatic logic [2:0] f_valid(int n, int d);
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = (n >= (i + 1) * d);
    return v;
  endfunction

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b1, 16'hABCD, 5'd4);
    drive(1'b0, 1'b1, 1'b1, 16'h1234, 5'd4);
    checks++;
    if (taps !== 48'd0) begin
      errors++; $display("FAIL reset_taps: got %h want 0", taps);
    end
    checks++;
    if (tap_valid !== 3'b000 || full !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got valid=%b full=%b want 000/0", tap_valid, full);
    end
    checks++;
    if (fill_count !== 6'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", fill_count);
    end
  endtask

  // D=4 streaming 1,2,3,... until well past saturation.
  task automatic test_basic_stream();
    for (int n = 1; n <= 52; n++) begin
      drive(1'b1, 1'b0, 1'b1, 16'(n), 5'd4);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (taps[16*i +: 16] !== f_tap(n, 4, i, 1)) begin
          errors++; $display("FAIL basic_tap%0d n=%0d: got %0d want %0d", i, n, taps[16*i +: 16], f_tap(n, 4, i, 1));
        end
      end
      checks++;
      if (tap_valid !== f_valid(n, 4) || full !== (n >= 12)) begin
        errors++; $display("FAIL basic_flags n=%0d: got valid=%b full=%b want %b/%0d", n, tap_valid, full, f_valid(n, 4), (n >= 12));
      end
      checks++;
      if (fill_count !== 6'((n < 48) ? n : 48)) begin
        errors++; $display("FAIL basic_count n=%0d: got %0d want %0d", n, fill_count, (n < 48) ? n : 48);
      end
    end
  endtask

  // delay_len=0 clamps to 1; delay_len=31 clamps to 16.
  task automatic test_clamp();
    drive(1'b1, 1'b1, 1'b0, 16'd0, 5'd0);
    for (int n = 1; n <= 3; n++) begin
      drive(1'b1, 1'b0, 1'b1, 16'(9 + n), 5'd7);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (taps[16*i +: 16] !== f_tap(n, 1, i, 10)) begin
          errors++; $display("FAIL clamp1_tap%0d n=%0d: got %0d want %0d", i, n, taps[16*i +: 16], f_tap(n, 1, i, 10));
        end
      end
      checks++;
      if (tap_valid !== f_valid(n, 1)) begin
        errors++; $display("FAIL clamp1_valid n=%0d: got %b want %b", n, tap_valid, f_valid(n, 1));
      end
    end
    drive(1'b1, 1'b1, 1'b0, 16'd0, 5'd31);
    for (int n = 1; n <= 34; n++) begin
      drive(1'b1, 1'b0, 1'b1, 16'(100 + n), 5'd1);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (taps[16*i +: 16] !== f_tap(n, 16, i, 101)) begin
          errors++; $display("FAIL clamp16_tap%0d n=%0d: got %0d want %0d", i, n, taps[16*i +: 16], f_tap(n, 16, i, 101));
        end
      end
      checks++;
      if (tap_valid !== f_valid(n, 16)) begin
        errors++; $display("FAIL clamp16_valid n=%0d: got %b want %b", n, tap_valid, f_valid(n, 16));
      end
    end
  endtask

  // Enable toggled: disabled cycles carry junk data and must change nothing.
  task automatic test_enable_toggle();
    int n;
    n = 0;
    drive(1'b1, 1'b1, 1'b0, 16'd0, 5'd4);
    for (int c = 0; c < 24; c++) begin
      if (c % 2 == 0) begin
        n++;
        drive(1'b1, 1'b0, 1'b1, 16'(n), 5'd4);
      end else begin
        drive(1'b1, 1'b0, 1'b0, 16'(500 + c), 5'd4);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (taps[16*i +: 16] !== f_tap(n, 4, i, 1)) begin
          errors++; $display("FAIL toggle_tap%0d c=%0d: got %0d want %0d", i, c, taps[16*i +: 16], f_tap(n, 4, i, 1));
        end
      end
      checks++;
      if (fill_count !== 6'(n) || tap_valid !== f_valid(n, 4)) begin
        errors++; $display("FAIL toggle_state c=%0d: got cnt=%0d valid=%b want %0d/%b", c, fill_count, tap_valid, n, f_valid(n, 4));
      end
    end
  endtask

  // Clear together with enable wins; sample 99 is discarded.
  task automatic test_clear_priority();
    drive(1'b1, 1'b1, 1'b0, 16'd0, 5'd4);
    for (int n = 1; n <= 14; n++) drive(1'b1, 1'b0, 1'b1, 16'(n), 5'd4);
    checks++;
    if (full !== 1'b1) begin
      errors++; $display("FAIL clrpri_prefull: got full=%b want 1", full);
    end
    drive(1'b1, 1'b1, 1'b1, 16'd99, 5'd4);
    checks++;
    if (taps !== 48'd0 || tap_valid !== 3'b000 || full !== 1'b0 || fill_count !== 6'd0) begin
      errors++; $display("FAIL clrpri_zero: got taps=%h valid=%b full=%b cnt=%0d want all 0", taps, tap_valid, full, fill_count);
    end
    for (int n = 1; n <= 13; n++) begin
      drive(1'b1, 1'b0, 1'b1, 16'(n), 5'd4);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (taps[16*i +: 16] !== f_tap(n, 4, i, 1)) begin
          errors++; $display("FAIL clrpri_tap%0d n=%0d: got %0d want %0d", i, n, taps[16*i +: 16], f_tap(n, 4, i, 1));
        end
      end
    end
  endtask

  // delay_len changes without clear are ignored; clear latches the new value.
  task automatic test_delay_change();
    drive(1'b1, 1'b1, 1'b0, 16'd0, 5'd4);
    for (int n = 1; n <= 9; n++) begin
      drive(1'b1, 1'b0, 1'b1, 16'(n), (n == 1) ? 5'd4 : 5'd2);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (taps[16*i +: 16] !== f_tap(n, 4, i, 1)) begin
          errors++; $display("FAIL dchg4_tap%0d n=%0d: got %0d want %0d", i, n, taps[16*i +: 16], f_tap(n, 4, i, 1));
        end
      end
      checks++;
      if (tap_valid !== f_valid(n, 4)) begin
        errors++; $display("FAIL dchg4_valid n=%0d: got %b want %b", n, tap_valid, f_valid(n, 4));
      end
    end
    drive(1'b1, 1'b1, 1'b0, 16'd0, 5'd2);
    for (int n = 1; n <= 8; n++) begin
      drive(1'b1, 1'b0, 1'b1, 16'(40 + n), 5'd9);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (taps[16*i +: 16] !== f_tap(n, 2, i, 41)) begin
          errors++; $display("FAIL dchg2_tap%0d n=%0d: got %0d want %0d", i, n, taps[16*i +: 16], f_tap(n, 2, i, 41));
        end
      end
      checks++;
      if (tap_valid !== f_valid(n, 2)) begin
        errors++; $display("FAIL dchg2_valid n=%0d: got %b want %b", n, tap_valid, f_valid(n, 2));
      end
    end
  endtask

  // Reset for one cycle at fill_count=7 discards everything; refill from x1.
  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b0, 16'd0, 5'd4);
    for (int n = 1; n <= 7; n++) drive(1'b1, 1'b0, 1'b1, 16'(n), 5'd4);
    checks++;
    if (fill_count !== 6'd7) begin
      errors++; $display("FAIL rstmid_pre: got cnt=%0d want 7", fill_count);
    end
    drive(1'b0, 1'b0, 1'b1, 16'd55, 5'd4);
    checks++;
    if (taps !== 48'd0 || tap_valid !== 3'b000 || full !== 1'b0 || fill_count !== 6'd0) begin
      errors++; $display("FAIL rstmid_zero: got taps=%h valid=%b full=%b cnt=%0d want all 0", taps, tap_valid, full, fill_count);
    end
    for (int n = 1; n <= 14; n++) begin
      drive(1'b1, 1'b0, 1'b1, 16'(n), 5'd4);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (taps[16*i +: 16] !== f_tap(n, 4, i, 1)) begin
          errors++; $display("FAIL rstmid_tap%0d n=%0d: got %0d want %0d", i, n, taps[16*i +: 16], f_tap(n, 4, i, 1));
        end
      end
      checks++;
      if (fill_count !== 6'(n) || full !== (n >= 12)) begin
        errors++; $display("FAIL rstmid_state n=%0d: got cnt=%0d full=%b want %0d/%0d", n, fill_count, full, n, (n >= 12));
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    enable    = 1'b0;
    shift_in  = '0;
    delay_len = 5'd4;
    test_reset();
    test_basic_stream();
    test_clamp();
    test_enable_toggle();
    test_clear_priority();
    test_delay_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/programmable_line_buffer.md
PROGRAMMABLE_LINE_BUFFER -- requirements
Module: programmable_line_buffer

Interface
REQ-001 SHALL provide parameter pNoTaps, default 3, number of cascaded delay taps.
REQ-002 SHALL provide parameter pMaxDelay, default 16, maximum per-tap delay in enabled shifts.
REQ-003 SHALL provide parameter pPtrLength, default 5, width of delay/pointer values; must hold pMaxDelay.
REQ-004 SHALL provide parameter pDataLength, default 16, sample width.
REQ-005 SHALL provide parameter pCountLength, default 6, fill-counter width; must hold pNoTaps*pMaxDelay.
REQ-006 SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-007 reset_n  input  1  synchronous active-low reset.
REQ-008 clear  input  1  synchronous flush; also loads delay_len.
REQ-009 enable  input  1  shift strobe; one sample accepted per high cycle.
REQ-010 delay_len  input  pPtrLength  requested per-tap delay D.
REQ-011 shift_in  input  pDataLength  incoming sample.
REQ-012 taps  output  pDataLength*pNoTaps  packed tap outputs; tap i at bits [pDataLength*(i+1)-1 : pDataLength*i].
REQ-013 tap_valid  output  pNoTaps  per-tap valid flags.
REQ-014 full  output  1  all taps valid.
REQ-015 fill_count  output  pCountLength  enabled shifts since last flush, saturating.

Function
REQ-016 Active delay D SHALL be latched from delay_len only in a cycle where reset_n=0 or clear=1; changes at other times SHALL be ignored.
REQ-017 Latched D SHALL be clamped: delay_len=0 -> D=1; delay_len>pMaxDelay -> D=pMaxDelay.
REQ-018 Samples accepted on enabled cycles SHALL be numbered x1, x2, ... from the last flush; n = count accepted so far.
REQ-019 Registered outputs: in the cycle after the n-th accepting edge, tap i SHALL equal x(n+1-(i+1)*D) when that index >= 1, else zero.
REQ-020 Equivalently, tap 0 delays shift_in by D enabled shifts and tap i delays tap i-1 by D enabled shifts (D=1 -> tap 0 = last accepted sample).
REQ-021 tap_valid[i] SHALL be 1 iff n >= (i+1)*D-1+1, i.e. the sample in tap i is a real sample; invalid taps SHALL read zero regardless of storage contents.
REQ-022 full SHALL equal AND of tap_valid.
REQ-023 fill_count SHALL increment by 1 per accepted sample and saturate at pNoTaps*pMaxDelay; no wrap.
REQ-024 enable=0 cycles SHALL hold all outputs and storage unchanged.
REQ-025 Storage SHALL be a per-tap circular buffer of pMaxDelay entries with a shared write pointer wrapping from D-1 to 0; pointer SHALL never exceed D-1.
REQ-026 clear=1 SHALL, on the next edge, zero fill_count, tap_valid, full, taps and the pointer, and latch D; storage need not be erased.
REQ-027 clear and enable high together: clear wins, shift_in discarded.
REQ-028 Continuous enable after full: outputs advance every cycle, flags stay high, fill_count stays saturated.
REQ-029 Arithmetic on indices and counts SHALL be unsigned; comparisons against (i+1)*D SHALL use pCountLength+1 bits to avoid overflow.

Reset
REQ-030 reset_n=0 at a rising edge SHALL zero taps, tap_valid, full, fill_count, pointer and latch D per REQ-016/017; reset_n dominates clear and enable.
REQ-031 Reset asserted mid-operation SHALL discard all buffered samples; first sample after release is x1.

Verification
REQ-032 Defaults, delay_len=4, reset, enable every cycle with shift_in=1,2,3,... -> tap0 shows 1 one cycle after 4th sample, tap1 shows 1 after 8th, tap2 after 12th; full rises after 12th; fill_count saturates at 48.
REQ-033 delay_len=0 at clear, stream 10,11,12 -> D=1: tap0=10 after first sample, tap2=10 after third; delay_len=31 at clear -> D=16.
REQ-034 delay_len=4, enable toggled 1/0 -> outputs and fill_count change only after enabled edges; tap0 first=1 after 4th enabled edge.
REQ-035 Fill to full, then assert clear together with enable and shift_in=99 -> next cycle all taps 0, flags 0, fill_count 0; 99 never appears.
REQ-036 Mid-stream change delay_len 4->2 without clear -> timing unchanged; after clear, tap0 valid after 2 samples.
REQ-037 Assert reset_n=0 for one cycle at fill_count=7 -> all outputs 0 next cycle; refill matches REQ-032 from x1.
